decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 41 ++++
 rtl/decode_stage.sv | 136 +++++++++++++
 tb/tb_decode_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - instruction, write-back and ALU-side signal bundle for decode_stage
//
// Signals
//   instr_valid/instr/instr_ready : upstream instruction handshake
//   wb_en/wb_addr/wb_data         : register-file write port from write-back
//   ex_valid/ex_ready             : handshake toward the ALU stage
//   opcode..rd_addr               : decoded fields presented with ex_valid
// Modports
//   master : the side that feeds instructions/write-backs and consumes operands
//   slave  : the decode stage itself
interface decode_stage_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;

    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  opcode;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [4:0]  shamt;
    logic [5:0]  ALU_control;
    logic [15:0] immediate;
    logic [4:0]  rd_addr;

    modport master (
        output instr_valid, instr, wb_en, wb_addr, wb_data, ex_ready,
        input  instr_ready, ex_valid, opcode, rs_content, rt_content,
               shamt, ALU_control, immediate, rd_addr
    );

    modport slave (
        input  instr_valid, instr, wb_en, wb_addr, wb_data, ex_ready,
        output instr_ready, ex_valid, opcode, rs_content, rt_content,
               shamt, ALU_control, immediate, rd_addr
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS decode stage: register file, operand capture, field decode
//
// Parameters
//   FWD_EN : 1 = a write-back on the capture edge is bypassed into the captured operands
// Ports
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : decode_stage_if.slave (instruction in, write-back in, operands out)
module decode_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    decode_stage_if.slave   bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Register file. Entry 0 is reset to zero and never written, so a read
    // of index 0 naturally returns 0.
    logic [31:0] rf [0:31];

    // Held output stage
    logic        ex_valid_q;
    logic [5:0]  opcode_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;
    logic [4:0]  shamt_q;
    logic [5:0]  alu_ctl_q;
    logic [15:0] imm_q;
    logic [4:0]  rd_q;

    // Combinational decode of the incoming word
    logic [5:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic        in_rtype;
    logic [31:0] rs_rf;
    logic [31:0] rt_rf;
    logic        fwd_rs;
    logic        fwd_rt;
    logic [31:0] rs_cap;
    logic [31:0] rt_cap;
    logic [4:0]  shamt_cap;
    logic [5:0]  alu_ctl_cap;
    logic [4:0]  rd_cap;
    logic        wb_write;
    logic        accept;

    assign in_op    = bus.instr[31:26];
    assign in_rs    = bus.instr[25:21];
    assign in_rt    = bus.instr[20:16];
    assign in_rd    = bus.instr[15:11];
    assign in_rtype = (in_op == OP_RTYPE);

    assign wb_write = bus.wb_en && (bus.wb_addr != 5'd0);

    // A stalled operand bundle blocks new instructions; a consumed one frees
    // the slot on the same edge, giving one instruction per cycle.
    assign bus.instr_ready = !ex_valid_q || bus.ex_ready;
    assign accept          = bus.instr_valid && bus.instr_ready;

    always_comb begin
        rs_rf = rf[in_rs];
        rt_rf = rf[in_rt];
    end

    // Bypass only real writes; index 0 is never bypassed since its write is dropped.
    assign fwd_rs = FWD_EN && wb_write && (bus.wb_addr == in_rs);
    assign fwd_rt = FWD_EN && wb_write && (bus.wb_addr == in_rt);
    assign rs_cap = fwd_rs ? bus.wb_data : rs_rf;
    assign rt_cap = fwd_rt ? bus.wb_data : rt_rf;

    assign shamt_cap   = in_rtype ? bus.instr[10:6] : 5'd0;
    assign alu_ctl_cap = in_rtype ? bus.instr[5:0]  : 6'd0;

    // Branches and stores write no register, so they carry destination 0.
    always_comb begin
        rd_cap = in_rt;
        case (in_op)
            OP_RTYPE:              rd_cap = in_rd;
            OP_BEQ, OP_BNE, OP_SW: rd_cap = 5'd0;
            default:               rd_cap = in_rt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_write) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Data fields only change on accept; a drain without a new instruction
    // just clears ex_valid and leaves the last operands visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            opcode_q   <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            shamt_q    <= '0;
            alu_ctl_q  <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            opcode_q   <= in_op;
            rs_q       <= rs_cap;
            rt_q       <= rt_cap;
            shamt_q    <= shamt_cap;
            alu_ctl_q  <= alu_ctl_cap;
            imm_q      <= bus.instr[15:0];
            rd_q       <= rd_cap;
        end else if (bus.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.opcode      = opcode_q;
    assign bus.rs_content  = rs_q;
    assign bus.rt_content  = rt_q;
    assign bus.shamt       = shamt_q;
    assign bus.ALU_control = alu_ctl_q;
    assign bus.immediate   = imm_q;
    assign bus.rd_addr     = rd_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage (bypass on and off)
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_ready;

    always #5 clk = ~clk;

    decode_stage_if bus1 ();
    decode_stage_if bus0 ();

    assign bus1.instr_valid = instr_valid;
    assign bus1.instr       = instr;
    assign bus1.wb_en       = wb_en;
    assign bus1.wb_addr     = wb_addr;
    assign bus1.wb_data     = wb_data;
    assign bus1.ex_ready    = ex_ready;
    assign bus0.instr_valid = instr_valid;
    assign bus0.instr       = instr;
    assign bus0.wb_en       = wb_en;
    assign bus0.wb_addr     = wb_addr;
    assign bus0.wb_data     = wb_data;
    assign bus0.ex_ready    = ex_ready;

    decode_stage #(.FWD_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    decode_stage #(.FWD_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural registers plus the operand bundle the ALU
    // should see. Index [f] of m_rs/m_rt is the view with bypass f (0 or 1).
    logic [31:0] m_rf [32];
    bit          m_valid;
    logic [5:0]  m_op;
    logic [31:0] m_rs [2];
    logic [31:0] m_rt [2];
    logic [4:0]  m_shamt;
    logic [5:0]  m_alu;
    logic [15:0] m_imm;
    logic [4:0]  m_rd;

    always @(posedge clk or negedge rst_n) begin
        bit take;
        int s;
        int t;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_valid = 1'b0;
            m_op = 0; m_shamt = 0; m_alu = 0; m_imm = 0; m_rd = 0;
            for (int f = 0; f < 2; f++) begin m_rs[f] = 0; m_rt[f] = 0; end
        end else begin
            take = instr_valid && (!m_valid || ex_ready);
            if (take) begin
                s = int'(instr[25:21]);
                t = int'(instr[20:16]);
                for (int f = 0; f < 2; f++) begin
                    m_rs[f] = (f == 1 && wb_en && int'(wb_addr) == s && s != 0) ? wb_data : m_rf[s];
                    m_rt[f] = (f == 1 && wb_en && int'(wb_addr) == t && t != 0) ? wb_data : m_rf[t];
                end
                m_op    = instr[31:26];
                m_imm   = instr[15:0];
                m_shamt = (m_op == 6'd0) ? instr[10:6] : 5'd0;
                m_alu   = (m_op == 6'd0) ? instr[5:0]  : 6'd0;
                if (m_op == 6'd0)
                    m_rd = instr[15:11];
                else if (m_op inside {6'd4, 6'd5, 6'd43})
                    m_rd = 5'd0;
                else
                    m_rd = instr[20:16];
                m_valid = 1'b1;
            end else if (ex_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
        end
    end

    task automatic cmp_bus(input int f, input logic ir, input logic ev, input logic [5:0] op,
                           input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] sh,
                           input logic [5:0] alu, input logic [15:0] imm, input logic [4:0] rd);
        string p;
        p = (f == 1) ? "fwd1" : "fwd0";
        chk({p, ".instr_ready"}, ir, !m_valid || ex_ready);
        chk({p, ".ex_valid"}, ev, m_valid);
        chk({p, ".opcode"}, op, m_op);
        chk({p, ".rs_content"}, rs, m_rs[f]);
        chk({p, ".rt_content"}, rt, m_rt[f]);
        chk({p, ".shamt"}, sh, m_shamt);
        chk({p, ".ALU_control"}, alu, m_alu);
        chk({p, ".immediate"}, imm, m_imm);
        chk({p, ".rd_addr"}, rd, m_rd);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            cmp_bus(1, bus1.instr_ready, bus1.ex_valid, bus1.opcode, bus1.rs_content, bus1.rt_content,
                    bus1.shamt, bus1.ALU_control, bus1.immediate, bus1.rd_addr);
            cmp_bus(0, bus0.instr_ready, bus0.ex_valid, bus0.opcode, bus0.rs_content, bus0.rt_content,
                    bus0.shamt, bus0.ALU_control, bus0.immediate, bus0.rd_addr);
        end
    end

    // Inputs change 2 time units after the falling edge, well clear of both edges.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        cyc();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] i);
        instr_valid = 1'b1; instr = i;
        cyc();
        instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
        cmp_on = 1'b1;
        repeat (2) cyc();
        chk("reset ex_valid", bus1.ex_valid, 0);
        chk("reset rs_content", bus1.rs_content, 0);
        rst_n = 1'b1;

        // and r3,r1,r2 with r1=15, r2=12
        wb(5'd1, 32'd15);
        wb(5'd2, 32'd12);
        issue(32'h00221824);
        chk("and ex_valid", bus1.ex_valid, 1);
        chk("and opcode", bus1.opcode, 0);
        chk("and rs", bus1.rs_content, 15);
        chk("and rt", bus1.rt_content, 12);
        chk("and alu", bus1.ALU_control, 6'b100100);
        chk("and shamt", bus1.shamt, 0);
        chk("and rd", bus1.rd_addr, 3);
        chk("and rs nofwd", bus0.rs_content, 15);

        // addi r2,r1,-1 with r1=23
        wb(5'd1, 32'd23);
        issue(32'h2022FFFF);
        chk("addi opcode", bus1.opcode, 6'b001000);
        chk("addi rs", bus1.rs_content, 23);
        chk("addi imm", bus1.immediate, 16'hFFFF);
        chk("addi alu", bus1.ALU_control, 0);
        chk("addi shamt", bus1.shamt, 0);
        chk("addi rd", bus1.rd_addr, 2);

        // Same-edge write-back of r1 while capturing
        instr_valid = 1'b1; instr = 32'h00221824;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd35;
        cyc();
        instr_valid = 1'b0; wb_en = 1'b0;
        chk("bypass rs fwd1", bus1.rs_content, 35);
        chk("bypass rs fwd0", bus0.rs_content, 23);

        // Stall three cycles while r1 keeps being rewritten
        ex_ready = 1'b0; instr_valid = 1'b1; instr = 32'h00411020;
        for (int i = 0; i < 3; i++) begin
            wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd100 + 32'(i);
            cyc();
            chk("stall instr_ready", bus1.instr_ready, 0);
            chk("stall rs fwd1", bus1.rs_content, 35);
            chk("stall rs fwd0", bus0.rs_content, 23);
        end
        wb_en = 1'b0; ex_ready = 1'b1;
        #1;
        chk("release instr_ready", bus1.instr_ready, 1);
        cyc();
        chk("release rs", bus1.rs_content, 12);
        chk("release rt", bus1.rt_content, 102);
        instr = 32'h00221824;
        cyc();
        chk("b2b ex_valid", bus1.ex_valid, 1);
        chk("b2b rs", bus1.rs_content, 102);
        instr_valid = 1'b0;
        cyc();
        chk("drain ex_valid", bus1.ex_valid, 0);
        chk("drain rs held", bus1.rs_content, 102);

        // r0 is not writable, not even through the bypass
        wb(5'd0, 32'hDEADBEEF);
        instr_valid = 1'b1; instr = 32'h00011020;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
        cyc();
        instr_valid = 1'b0; wb_en = 1'b0;
        chk("r0 rs fwd1", bus1.rs_content, 0);
        chk("r0 rs fwd0", bus0.rs_content, 0);
        issue(32'h10220004);
        chk("beq opcode", bus1.opcode, 4);
        chk("beq rd", bus1.rd_addr, 0);
        issue(32'hAC220008);
        chk("sw rd", bus1.rd_addr, 0);
        issue(32'h14220003);
        chk("bne rd", bus1.rd_addr, 0);

        // instr ignored without instr_valid
        instr = 32'hFFFFFFFF;
        cyc();
        chk("ignored opcode", bus1.opcode, 5);

        // Asynchronous reset between edges with a held instruction
        issue(32'h00221824);
        chk("pre-reset ex_valid", bus1.ex_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async ex_valid", bus1.ex_valid, 0);
        chk("async rs", bus1.rs_content, 0);
        chk("async rt", bus1.rt_content, 0);
        chk("async alu", bus1.ALU_control, 0);
        chk("async rd", bus1.rd_addr, 0);
        chk("async fwd0 ex_valid", bus0.ex_valid, 0);
        cyc();
        rst_n = 1'b1;
        issue(32'h00221824);
        chk("post-reset ex_valid", bus1.ex_valid, 1);
        chk("post-reset rs", bus1.rs_content, 0);
        chk("post-reset rt", bus1.rt_content, 0);
        cyc();

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
